// File: rtl/dma_stream_fifo.sv
// -----------------------------------------------------------------------------
// dma_stream_fifo
//
// Data buffer between the DMA read engine (producer, push/full) and the DMA
// write engine (consumer, valid/ready stream with first-word-fall-through).
// Supports any depth >= 2 (pointers wrap explicitly at SLOTS-1), reports its
// occupancy, compares it against programmable almost-full/almost-empty
// thresholds and keeps sticky overflow/underflow error flags.
//
// Optional build macro:
//   DMA_FIFO_OUTREG_EN - head of memory is registered into an output flop
//                        stage; push-to-valid latency becomes 2 cycles while
//                        capacity (SLOTS) and 1 word/cycle throughput are kept.
//
// Parameters:
//   SLOTS  number of entries (>= 2)
//   WIDTH  data word width
//   LW     width of level/threshold ports (derived, do not override)
//
// Ports:
//   clk             clock
//   rstn            asynchronous active-low reset
//   clear_i         synchronous flush of pointers, level and error flags
//   write_i/data_i  push request and data
//   full_o          no free slot
//   out_valid_o     head entry valid
//   out_ready_i     consumer accepts head entry
//   out_data_o      head entry data (0 when not valid)
//   level_o         entries held, 0..SLOTS
//   af_thresh_i     almost-full threshold  (almost_full_o  = level >= thresh)
//   ae_thresh_i     almost-empty threshold (almost_empty_o = level <= thresh)
//   overflow_o      sticky: push attempted while full
//   underflow_o     sticky: ready asserted while not valid
// -----------------------------------------------------------------------------

`ifndef DMA_FIFO_DEPTH
`define DMA_FIFO_DEPTH 8
`endif
`ifndef DMA_DATA_WIDTH
`define DMA_DATA_WIDTH 32
`endif

module dma_stream_fifo #(
    parameter int SLOTS = `DMA_FIFO_DEPTH,
    parameter int WIDTH = `DMA_DATA_WIDTH,
    parameter int LW    = $clog2(SLOTS + 1)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clear_i,
    input  logic             write_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             full_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic [LW-1:0]    level_o,
    input  logic [LW-1:0]    af_thresh_i,
    input  logic [LW-1:0]    ae_thresh_i,
    output logic             almost_full_o,
    output logic             almost_empty_o,
    output logic             overflow_o,
    output logic             underflow_o
);

    localparam int             PW         = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam logic [PW-1:0]  LAST_PTR   = PW'(SLOTS - 1);
    localparam logic [LW-1:0]  FULL_LEVEL = LW'(SLOTS);

    logic [WIDTH-1:0] mem [SLOTS];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [LW-1:0]    level;
    logic             overflow;
    logic             underflow;
    logic             push;
    logic             pop;
    logic             rd_adv;     // read pointer advances (memory head consumed)
    logic             valid;      // head visible to the consumer

    // Explicit wrap so non-power-of-2 depths never alias onto unused slots.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    assign full_o = (level == FULL_LEVEL);
    assign push   = write_i & ~full_o;
    assign pop    = valid & out_ready_i;

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (push && !clear_i) begin
            mem[wr_ptr] <= data_i;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clear_i) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (rd_adv) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (push && !pop) begin
                level <= level + LW'(1);
            end else if (pop && !push) begin
                level <= level - LW'(1);
            end
            if (write_i && full_o) begin
                overflow <= 1'b1;
            end
            if (out_ready_i && !valid) begin
                underflow <= 1'b1;
            end
        end
    end

`ifdef DMA_FIFO_OUTREG_EN
    logic             oreg_valid;
    logic [WIDTH-1:0] oreg_data;
    logic [LW-1:0]    mem_count;

    // level counts the output register too, so memory holds level minus it.
    assign mem_count = level - LW'(oreg_valid);
    assign valid     = oreg_valid;
    // Refill the output stage whenever it is empty or being drained this cycle;
    // loading in the same cycle as a pop keeps 1 word/cycle streaming.
    assign rd_adv    = (mem_count != '0) & (~oreg_valid | pop);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            oreg_valid <= 1'b0;
            oreg_data  <= '0;
        end else if (clear_i) begin
            oreg_valid <= 1'b0;
        end else if (rd_adv) begin
            oreg_valid <= 1'b1;
            oreg_data  <= mem[rd_ptr];
        end else if (pop) begin
            oreg_valid <= 1'b0;
        end
    end

    assign out_valid_o = oreg_valid;
    assign out_data_o  = oreg_valid ? oreg_data : '0;
`else
    assign valid       = (level != '0);
    assign rd_adv      = pop;
    assign out_valid_o = valid;
    assign out_data_o  = valid ? mem[rd_ptr] : '0;
`endif

    assign level_o        = level;
    assign almost_full_o  = (level >= af_thresh_i);
    assign almost_empty_o = (level <= ae_thresh_i);
    assign overflow_o     = overflow;
    assign underflow_o    = underflow;

endmodule

// File: tb/tb_dma_stream_fifo.sv
// -----------------------------------------------------------------------------
// Testbench for dma_stream_fifo (SLOTS=6, WIDTH=32).
// Reference model: a queue of {data, push cycle}; an entry is visible once it
// heads the queue and has aged LAT cycles (1 cycle, 2 with the output stage).
// -----------------------------------------------------------------------------
module tb_dma_stream_fifo;

    localparam int SLOTS = 6;
    localparam int WIDTH = 32;
    localparam int LW    = $clog2(SLOTS + 1);
`ifdef DMA_FIFO_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             clear_i = 1'b0;
    logic             write_i = 1'b0;
    logic [WIDTH-1:0] data_i = '0;
    logic             out_ready_i = 1'b0;
    logic [LW-1:0]    af_thresh_i = LW'(5);
    logic [LW-1:0]    ae_thresh_i = LW'(1);
    logic             full_o;
    logic             out_valid_o;
    logic [WIDTH-1:0] out_data_o;
    logic [LW-1:0]    level_o;
    logic             almost_full_o;
    logic             almost_empty_o;
    logic             overflow_o;
    logic             underflow_o;

    always #5 clk = ~clk;

    dma_stream_fifo #(.SLOTS(SLOTS), .WIDTH(WIDTH)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .clear_i        (clear_i),
        .write_i        (write_i),
        .data_i         (data_i),
        .full_o         (full_o),
        .out_valid_o    (out_valid_o),
        .out_ready_i    (out_ready_i),
        .out_data_o     (out_data_o),
        .level_o        (level_o),
        .af_thresh_i    (af_thresh_i),
        .ae_thresh_i    (ae_thresh_i),
        .almost_full_o  (almost_full_o),
        .almost_empty_o (almost_empty_o),
        .overflow_o     (overflow_o),
        .underflow_o    (underflow_o)
    );

    typedef struct {
        logic [WIDTH-1:0] data;
        int               cyc;
    } entry_t;

    entry_t q[$];
    bit     m_ovf = 1'b0;
    bit     m_unf = 1'b0;
    int     cyc = 0;
    int     checks = 0;
    int     errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit m_valid();
        return (q.size() != 0) && (q[0].cyc <= cyc - LAT);
    endfunction

    task automatic apply(input logic w, input logic [WIDTH-1:0] d, input logic r, input logic c);
        @(negedge clk);
        write_i     = w;
        data_i      = d;
        out_ready_i = r;
        clear_i     = c;
        #1;
    endtask

    task automatic check_model();
        bit v;
        v = m_valid();
        check("level", 64'(level_o), 64'(q.size()));
        check("valid", 64'(out_valid_o), 64'(v));
        check("data", 64'(out_data_o), v ? 64'(q[0].data) : 64'd0);
        check("full", 64'(full_o), 64'(q.size() == SLOTS));
        check("almost_full", 64'(almost_full_o), 64'(q.size() >= int'(af_thresh_i)));
        check("almost_empty", 64'(almost_empty_o), 64'(q.size() <= int'(ae_thresh_i)));
        check("overflow", 64'(overflow_o), 64'(m_ovf));
        check("underflow", 64'(underflow_o), 64'(m_unf));
    endtask

    task automatic advance();
        bit v;
        bit f;
        entry_t e;
        v = m_valid();
        f = (q.size() == SLOTS);
        @(posedge clk);
        if (clear_i) begin
            q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            if (write_i && f) m_ovf = 1'b1;
            if (out_ready_i && !v) m_unf = 1'b1;
            if (v && out_ready_i) void'(q.pop_front());
            if (write_i && !f) begin
                e.data = data_i;
                e.cyc  = cyc;
                q.push_back(e);
            end
        end
        cyc++;
    endtask

    task automatic step(input logic w, input logic [WIDTH-1:0] d, input logic r, input logic c);
        apply(w, d, r, c);
        check_model();
        advance();
    endtask

    typedef struct {
        logic             w;
        logic [WIDTH-1:0] d;
        logic             r;
        int               lvl;
        logic             v;
        logic [WIDTH-1:0] dat;
        logic             full;
        logic             af;
        logic             ae;
        logic             ovf;
    } vec_t;

    vec_t tbl[15];

    initial begin
        int first_pop;
        int pops;
        int last_pop;

        // Fill, overflow attempt, ordered drain (af=5, ae=1).
        tbl[0]  = '{1'b1, 32'hA0, 1'b0, 0, 1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[1]  = '{1'b1, 32'hA1, 1'b0, 1, 1'b1, 32'hA0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[2]  = '{1'b1, 32'hA2, 1'b0, 2, 1'b1, 32'hA0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 32'hA3, 1'b0, 3, 1'b1, 32'hA0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 32'hA4, 1'b0, 4, 1'b1, 32'hA0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 32'hA5, 1'b0, 5, 1'b1, 32'hA0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 32'hFF, 1'b0, 6, 1'b1, 32'hA0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 32'h00, 1'b0, 6, 1'b1, 32'hA0, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 32'h00, 1'b1, 6, 1'b1, 32'hA0, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[9]  = '{1'b0, 32'h00, 1'b1, 5, 1'b1, 32'hA1, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[10] = '{1'b0, 32'h00, 1'b1, 4, 1'b1, 32'hA2, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[11] = '{1'b0, 32'h00, 1'b1, 3, 1'b1, 32'hA3, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[12] = '{1'b0, 32'h00, 1'b1, 2, 1'b1, 32'hA4, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[13] = '{1'b0, 32'h00, 1'b1, 1, 1'b1, 32'hA5, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[14] = '{1'b0, 32'h00, 1'b0, 0, 1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 1'b1};

        // Reset state
        #1;
        check("rst_level", 64'(level_o), 64'd0);
        check("rst_valid", 64'(out_valid_o), 64'd0);
        check("rst_data", 64'(out_data_o), 64'd0);
        check("rst_full", 64'(full_o), 64'd0);
        check("rst_ovf", 64'(overflow_o), 64'd0);
        check("rst_unf", 64'(underflow_o), 64'd0);
        check("rst_ae", 64'(almost_empty_o), 64'd1);
        check("rst_af", 64'(almost_full_o), 64'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;

`ifndef DMA_FIFO_OUTREG_EN
        for (int i = 0; i < 15; i++) begin
            apply(tbl[i].w, tbl[i].d, tbl[i].r, 1'b0);
            check($sformatf("tbl%0d_level", i), 64'(level_o), 64'(tbl[i].lvl));
            check($sformatf("tbl%0d_valid", i), 64'(out_valid_o), 64'(tbl[i].v));
            check($sformatf("tbl%0d_data", i), 64'(out_data_o), 64'(tbl[i].dat));
            check($sformatf("tbl%0d_full", i), 64'(full_o), 64'(tbl[i].full));
            check($sformatf("tbl%0d_af", i), 64'(almost_full_o), 64'(tbl[i].af));
            check($sformatf("tbl%0d_ae", i), 64'(almost_empty_o), 64'(tbl[i].ae));
            check($sformatf("tbl%0d_ovf", i), 64'(overflow_o), 64'(tbl[i].ovf));
            check_model();
            advance();
        end
`else
        for (int i = 0; i < 7; i++) step(1'b1, (i < 6) ? 32'hA0 + i : 32'hFF, 1'b0, 1'b0);
        for (int i = 0; i < 10 && q.size() != 0; i++) step(1'b0, '0, m_valid(), 1'b0);
`endif
        step(1'b0, '0, 1'b0, 1'b1);

        // Wrap with concurrency: level holds while pushing and popping.
        step(1'b1, 32'h00, 1'b0, 1'b0);
        for (int i = 1; i < 10; i++) begin
            apply(1'b1, WIDTH'(i), 1'b1, 1'b0);
            if (LAT == 1) check("wrap_level", 64'(level_o), 64'd1);
            check_model();
            advance();
        end
        for (int i = 0; i < 10 && q.size() != 0; i++) step(1'b0, '0, m_valid(), 1'b0);

        // Underflow then clear together with a write.
        step(1'b0, '0, 1'b1, 1'b0);
        apply(1'b0, '0, 1'b0, 1'b0);
        check("unf_set", 64'(underflow_o), 64'd1);
        check_model();
        advance();
        step(1'b1, 32'h77, 1'b0, 1'b1);
        apply(1'b0, '0, 1'b0, 1'b0);
        check("clr_level", 64'(level_o), 64'd0);
        check("clr_valid", 64'(out_valid_o), 64'd0);
        check("clr_ovf", 64'(overflow_o), 64'd0);
        check("clr_unf", 64'(underflow_o), 64'd0);
        check_model();
        advance();

        // Push-to-valid latency.
        step(1'b1, 32'h11, 1'b0, 1'b0);
        apply(1'b0, '0, 1'b0, 1'b0);
        check("lat_n1_valid", 64'(out_valid_o), 64'(LAT == 1));
        check_model();
        advance();
        apply(1'b0, '0, 1'b0, 1'b0);
        check("lat_n2_valid", 64'(out_valid_o), 64'd1);
        check("lat_n2_data", 64'(out_data_o), 64'h11);
        check_model();
        advance();
        step(1'b0, '0, 1'b1, 1'b0);

        // Back-to-back stream with ready held high: one word per cycle.
        first_pop = -1;
        last_pop  = -1;
        pops      = 0;
        for (int i = 0; i < 10; i++) begin
            apply(i < 6, 32'hB0 + i, 1'b1, 1'b0);
            if (out_valid_o) begin
                if (first_pop < 0) first_pop = i;
                last_pop = i;
                pops++;
            end
            check_model();
            advance();
        end
        check("stream_pops", 64'(pops), 64'd6);
        check("stream_span", 64'(last_pop - first_pop), 64'd5);
        step(1'b0, '0, 1'b0, 1'b1);

        // Asynchronous reset mid-cycle with level 3.
        for (int i = 0; i < 3; i++) step(1'b1, 32'hC0 + i, 1'b0, 1'b0);
        #3;
        write_i = 1'b0;
        rstn    = 1'b0;
        #1;
        check("arst_level", 64'(level_o), 64'd0);
        check("arst_valid", 64'(out_valid_o), 64'd0);
        check("arst_data", 64'(out_data_o), 64'd0);
        check("arst_full", 64'(full_o), 64'd0);
        q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        step(1'b1, 32'h55, 1'b0, 1'b0);
        apply(1'b0, '0, 1'b0, 1'b0);
        check("arst_push_data", 64'(out_data_o), (LAT == 1) ? 64'h55 : 64'h0);
        check_model();
        advance();
        for (int i = 0; i < 4 && q.size() != 0; i++) step(1'b0, '0, m_valid(), 1'b0);

        // Randomized traffic with changing thresholds.
        for (int i = 0; i < 400; i++) begin
            af_thresh_i = LW'($urandom_range(0, 7));
            ae_thresh_i = LW'($urandom_range(0, 7));
            step($urandom_range(0, 99) < 65, $urandom, $urandom_range(0, 99) < 55,
                 $urandom_range(0, 99) < 2);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
